phy_tx_lane_scheduler: RTL and testbench



---
 rtl/phy_tx_lane_scheduler.sv | 173 +++++++++++++++++
 tb/tb_phy_tx_lane_scheduler.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/phy_tx_lane_scheduler.sv
// Four-lane round-robin byte scheduler feeding the PHY TX serializer through one registered output slot.
// Optional build macro STRICT_STRIPE_EN selects fixed 0,1,2,3 striping with IDLE_BYTE fill for empty lanes.
module phy_tx_lane_scheduler #(
  parameter int unsigned       DATA_W    = 8,
  parameter logic [DATA_W-1:0] IDLE_BYTE = 8'hBC
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              enable,
  input  logic [DATA_W-1:0] In0,
  input  logic [DATA_W-1:0] In1,
  input  logic [DATA_W-1:0] In2,
  input  logic [DATA_W-1:0] In3,
  input  logic              valid0,
  input  logic              valid1,
  input  logic              valid2,
  input  logic              valid3,
  output logic              pop0,
  output logic              pop1,
  output logic              pop2,
  output logic              pop3,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  input  logic              out_ready,
  output logic              active,
  output logic [1:0]        last_lane
);

  typedef enum logic [1:0] {
    S_OFF   = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [1:0]        r_ptr;
  logic [1:0]        w_ptr_nxt;
  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] w_data_nxt;
  logic              r_valid;
  logic              w_valid_nxt;
  logic [1:0]        r_lane;
  logic [1:0]        w_lane_nxt;

  logic [DATA_W-1:0] w_in [4];
  logic [3:0]        w_valid_vec;
  logic [3:0]        w_pop;
  logic              w_load_slot;
  logic              w_found;
  logic [1:0]        w_win;
  logic [1:0]        w_cand;

  assign w_in[0]     = In0;
  assign w_in[1]     = In1;
  assign w_in[2]     = In2;
  assign w_in[3]     = In3;
  assign w_valid_vec = {valid3, valid2, valid1, valid0};

  // The output slot can take a new byte when it is empty or its byte leaves this cycle.
  assign w_load_slot = ~r_valid | out_ready;

  // Candidate search: the winner is the first valid lane starting at r_ptr.
  always_comb begin
    w_found = 1'b0;
    w_win   = r_ptr;
    w_cand  = r_ptr;
`ifdef STRICT_STRIPE_EN
    w_found = w_valid_vec[r_ptr];
`else
    for (int i = 0; i < 4; i++) begin
      w_cand = r_ptr + 2'(i);
      if (!w_found && w_valid_vec[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end
`endif
  end

  // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_data_nxt  = r_data;
    w_valid_nxt = r_valid;
    w_lane_nxt  = r_lane;
    w_pop       = 4'b0000;

    unique case (r_state)
      S_OFF: begin
        w_valid_nxt = 1'b0;
        w_data_nxt  = IDLE_BYTE;
        if (enable) begin
          w_state_nxt = S_RUN;
        end
      end

      S_RUN: begin
        if (!enable) begin
          // No grant in the cycle enable is seen low; only retire an accepted byte.
          w_state_nxt = S_DRAIN;
          if (w_load_slot) begin
            w_valid_nxt = 1'b0;
            w_data_nxt  = IDLE_BYTE;
          end
        end else if (w_load_slot) begin
          if (w_found) begin
            w_pop[w_win] = 1'b1;
            w_data_nxt   = w_in[w_win];
          end else begin
            w_data_nxt   = IDLE_BYTE;
          end
`ifdef STRICT_STRIPE_EN
          w_valid_nxt = 1'b1;
          w_lane_nxt  = r_ptr;
          w_ptr_nxt   = r_ptr + 2'd1;
`else
          w_valid_nxt = w_found;
          if (w_found) begin
            w_lane_nxt = w_win;
            w_ptr_nxt  = w_win + 2'd1;
          end
`endif
        end
      end

      S_DRAIN: begin
        if (w_load_slot) begin
          w_state_nxt = S_OFF;
          w_valid_nxt = 1'b0;
          w_data_nxt  = IDLE_BYTE;
        end
      end

      default: begin
        w_state_nxt = S_OFF;
      end
    endcase

    // A lane must never see a pop while the block is held in reset.
    if (!reset_L) begin
      w_pop = 4'b0000;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      r_state <= S_OFF;
      r_ptr   <= 2'd0;
      r_valid <= 1'b0;
      r_data  <= IDLE_BYTE;
      r_lane  <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_valid <= w_valid_nxt;
      r_data  <= w_data_nxt;
      r_lane  <= w_lane_nxt;
    end
  end

  assign pop0      = w_pop[0];
  assign pop1      = w_pop[1];
  assign pop2      = w_pop[2];
  assign pop3      = w_pop[3];
  assign data_out  = r_data;
  assign valid_out = r_valid;
  assign last_lane = r_lane;
  assign active    = (r_state != S_OFF);

endmodule

// File: tb/tb_phy_tx_lane_scheduler.sv
// Scenario bench for phy_tx_lane_scheduler: per-scenario inline checks plus a byte scoreboard on accepted output.
module tb_phy_tx_lane_scheduler;

  typedef struct {
    logic [7:0] data;
    logic [1:0] lane;
  } sb_entry_t;

  logic       clk;
  logic       reset_L;
  logic       enable;
  logic [7:0] In0, In1, In2, In3;
  logic       valid0, valid1, valid2, valid3;
  logic       pop0, pop1, pop2, pop3;
  logic [7:0] data_out;
  logic       valid_out;
  logic       out_ready;
  logic       active;
  logic [1:0] last_lane;

  logic [3:0] pops;
  assign pops = {pop3, pop2, pop1, pop0};

  sb_entry_t sb_q[$];
  sb_entry_t sb_e;
  int        n_checks = 0;
  int        n_pass   = 0;

  phy_tx_lane_scheduler #(.DATA_W(8), .IDLE_BYTE(8'hBC)) dut (
    .clk       (clk),
    .reset_L   (reset_L),
    .enable    (enable),
    .In0       (In0),
    .In1       (In1),
    .In2       (In2),
    .In3       (In3),
    .valid0    (valid0),
    .valid1    (valid1),
    .valid2    (valid2),
    .valid3    (valid3),
    .pop0      (pop0),
    .pop1      (pop1),
    .pop2      (pop2),
    .pop3      (pop3),
    .data_out  (data_out),
    .valid_out (valid_out),
    .out_ready (out_ready),
    .active    (active),
    .last_lane (last_lane)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog");
  end

  // Scoreboard: every byte accepted downstream must match the oldest expected entry.
  always @(negedge clk) begin
    if (reset_L === 1'b1 && valid_out === 1'b1 && out_ready === 1'b1) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        $display("FAIL sb_unexpected: got data=%02h lane=%0d, required no output", data_out, last_lane);
      end else begin
        sb_e = sb_q.pop_front();
        if (data_out !== sb_e.data || last_lane !== sb_e.lane)
          $display("FAIL sb_byte: got data=%02h lane=%0d, required data=%02h lane=%0d",
                   data_out, last_lane, sb_e.data, sb_e.lane);
        else
          n_pass++;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lanes(input logic [3:0] v, input logic [7:0] d0, input logic [7:0] d1,
                           input logic [7:0] d2, input logic [7:0] d3);
    {valid3, valid2, valid1, valid0} = v;
    In0 = d0;
    In1 = d1;
    In2 = d2;
    In3 = d3;
  endtask

  task automatic push_exp(input logic [7:0] d, input logic [1:0] l);
    sb_entry_t e;
    e.data = d;
    e.lane = l;
    sb_q.push_back(e);
  endtask

  task automatic randomize_inputs();
    enable    = 1'($urandom);
    out_ready = 1'($urandom);
    set_lanes(4'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
  endtask

  task automatic test_reset();
    reset_L = 1'b0;
    randomize_inputs();
    cyc();
    randomize_inputs();
    cyc();
    randomize_inputs();
    @(negedge clk);
    n_checks++;
    if (valid_out !== 1'b0) $display("FAIL reset_valid_out: got %b, required 0", valid_out);
    else n_pass++;
    n_checks++;
    if (data_out !== 8'hBC) $display("FAIL reset_data_out: got %02h, required bc", data_out);
    else n_pass++;
    n_checks++;
    if (pops !== 4'b0000) $display("FAIL reset_pops: got %b, required 0000", pops);
    else n_pass++;
    n_checks++;
    if (active !== 1'b0) $display("FAIL reset_active: got %b, required 0", active);
    else n_pass++;
    n_checks++;
    if (last_lane !== 2'd0) $display("FAIL reset_last_lane: got %0d, required 0", last_lane);
    else n_pass++;
    cyc();
    reset_L   = 1'b1;
    enable    = 1'b0;
    out_ready = 1'b1;
    set_lanes(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_pop [5];
    logic [7:0] exp_dat [5];
    logic [1:0] exp_ln  [5];
    exp_pop = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_dat = '{8'hFF, 8'hEE, 8'hDD, 8'hCC, 8'hFF};
    exp_ln  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    enable    = 1'b1;
    out_ready = 1'b1;
    set_lanes(4'b1111, 8'hFF, 8'hEE, 8'hDD, 8'hCC);
    @(negedge clk);
    n_checks++;
    if (pops !== 4'b0000) $display("FAIL rr_off_no_pop: got %b, required 0000", pops);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      cyc();
      @(negedge clk);
      n_checks++;
      if (pops !== exp_pop[i]) $display("FAIL rr_pop%0d: got %b, required %b", i, pops, exp_pop[i]);
      else n_pass++;
      if (i > 0) begin
        n_checks++;
        if (data_out !== exp_dat[i-1])
          $display("FAIL rr_latency%0d: got %02h, required %02h", i, data_out, exp_dat[i-1]);
        else n_pass++;
      end
      push_exp(exp_dat[i], exp_ln[i]);
    end
    cyc();
    set_lanes(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    cyc();
    @(negedge clk);
    n_checks++;
    if (valid_out !== 1'b0 || data_out !== 8'hBC)
      $display("FAIL rr_idle: got valid=%b data=%02h, required valid=0 data=bc", valid_out, data_out);
    else n_pass++;
  endtask

  task automatic test_skip_wrap();
    reset_L = 1'b0;
    enable  = 1'b0;
    cyc();
    reset_L = 1'b1;
    enable  = 1'b1;
    set_lanes(4'b0100, 8'h11, 8'h22, 8'h77, 8'h33);
    @(negedge clk);
    cyc();
    @(negedge clk);
    n_checks++;
    if (pops !== 4'b0100) $display("FAIL skip_pop2: got %b, required 0100", pops);
    else n_pass++;
    push_exp(8'h77, 2'd2);
    cyc();
    set_lanes(4'b0010, 8'h11, 8'h55, 8'h77, 8'h33);
    @(negedge clk);
    n_checks++;
    if (data_out !== 8'h77 || last_lane !== 2'd2)
      $display("FAIL skip_out: got data=%02h lane=%0d, required data=77 lane=2", data_out, last_lane);
    else n_pass++;
    n_checks++;
    if (pops !== 4'b0010) $display("FAIL wrap_pop1: got %b, required 0010", pops);
    else n_pass++;
    push_exp(8'h55, 2'd1);
    cyc();
    set_lanes(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    cyc();
    set_lanes(4'b1000, 8'h00, 8'h00, 8'h00, 8'hBB);
    @(negedge clk);
    n_checks++;
    if (pops !== 4'b1000) $display("FAIL bp_pop3: got %b, required 1000", pops);
    else n_pass++;
    push_exp(8'hBB, 2'd3);
    cyc();
    out_ready = 1'b0;
    set_lanes(4'b1111, 8'h10, 8'h20, 8'h30, 8'h40);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (pops !== 4'b0000 || data_out !== 8'hBB || valid_out !== 1'b1 || last_lane !== 2'd3)
        $display("FAIL bp_hold%0d: got pops=%b data=%02h valid=%b lane=%0d, required 0000/bb/1/3",
                 i, pops, data_out, valid_out, last_lane);
      else n_pass++;
      cyc();
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (pops !== 4'b0001) $display("FAIL bp_release_pop0: got %b, required 0001", pops);
    else n_pass++;
    push_exp(8'h10, 2'd0);
    cyc();
    set_lanes(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
  endtask

  task automatic test_drain();
    cyc();
    set_lanes(4'b0010, 8'h00, 8'hAA, 8'h00, 8'h00);
    @(negedge clk);
    n_checks++;
    if (pops !== 4'b0010) $display("FAIL drain_load_pop1: got %b, required 0010", pops);
    else n_pass++;
    push_exp(8'hAA, 2'd1);
    cyc();
    out_ready = 1'b0;
    enable    = 1'b0;
    set_lanes(4'b1111, 8'h01, 8'h02, 8'h03, 8'h04);
    @(negedge clk);
    n_checks++;
    if (pops !== 4'b0000 || active !== 1'b1)
      $display("FAIL drain_enable_low: got pops=%b active=%b, required 0000/1", pops, active);
    else n_pass++;
    cyc();
    enable = 1'b1;
    @(negedge clk);
    n_checks++;
    if (pops !== 4'b0000 || active !== 1'b1 || valid_out !== 1'b1 || data_out !== 8'hAA)
      $display("FAIL drain_hold: got pops=%b active=%b valid=%b data=%02h, required 0000/1/1/aa",
               pops, active, valid_out, data_out);
    else n_pass++;
    cyc();
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (pops !== 4'b0000) $display("FAIL drain_accept_no_pop: got %b, required 0000", pops);
    else n_pass++;
    cyc();
    enable = 1'b0;
    @(negedge clk);
    n_checks++;
    if (active !== 1'b0 || valid_out !== 1'b0 || data_out !== 8'hBC || pops !== 4'b0000)
      $display("FAIL drain_off: got active=%b valid=%b data=%02h pops=%b, required 0/0/bc/0000",
               active, valid_out, data_out, pops);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    cyc();
    enable    = 1'b1;
    out_ready = 1'b0;
    set_lanes(4'b0001, 8'h5A, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    cyc();
    @(negedge clk);
    n_checks++;
    if (pops !== 4'b0001) $display("FAIL rstmid_pop0: got %b, required 0001", pops);
    else n_pass++;
    push_exp(8'h5A, 2'd0);
    cyc();
    reset_L   = 1'b0;
    out_ready = 1'b1;
    set_lanes(4'b1111, 8'h01, 8'h02, 8'h03, 8'h04);
    @(negedge clk);
    n_checks++;
    if (pops !== 4'b0000) $display("FAIL rstmid_pop_gated: got %b, required 0000", pops);
    else n_pass++;
    cyc();
    reset_L = 1'b1;
    enable  = 1'b0;
    n_checks++;
    if (sb_q.size() != 1) $display("FAIL rstmid_pending: got %0d entries, required 1", sb_q.size());
    else n_pass++;
    if (sb_q.size() > 0) sb_e = sb_q.pop_front();
    @(negedge clk);
    n_checks++;
    if (valid_out !== 1'b0 || active !== 1'b0 || data_out !== 8'hBC || last_lane !== 2'd0)
      $display("FAIL rstmid_state: got valid=%b active=%b data=%02h lane=%0d, required 0/0/bc/0",
               valid_out, active, data_out, last_lane);
    else n_pass++;
  endtask

  task automatic test_stripe();
    logic [3:0] exp_pop [4];
    logic [7:0] exp_dat [4];
    logic [1:0] exp_ln  [4];
`ifdef STRICT_STRIPE_EN
    exp_pop = '{4'b0001, 4'b0010, 4'b0000, 4'b1000};
    exp_dat = '{8'h01, 8'h02, 8'hBC, 8'h04};
    exp_ln  = '{2'd0, 2'd1, 2'd2, 2'd3};
`else
    exp_pop = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
    exp_dat = '{8'h01, 8'h02, 8'h04, 8'h01};
    exp_ln  = '{2'd0, 2'd1, 2'd3, 2'd0};
`endif
    cyc();
    enable    = 1'b1;
    out_ready = 1'b1;
    set_lanes(4'b1011, 8'h01, 8'h02, 8'h03, 8'h04);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      cyc();
      @(negedge clk);
      n_checks++;
      if (pops !== exp_pop[i]) $display("FAIL stripe_pop%0d: got %b, required %b", i, pops, exp_pop[i]);
      else n_pass++;
      push_exp(exp_dat[i], exp_ln[i]);
    end
    cyc();
    enable = 1'b0;
    set_lanes(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    cyc();
    @(negedge clk);
    n_checks++;
    if (active !== 1'b1 || valid_out !== 1'b0)
      $display("FAIL stripe_drain: got active=%b valid=%b, required 1/0", active, valid_out);
    else n_pass++;
    cyc();
    @(negedge clk);
    n_checks++;
    if (active !== 1'b0) $display("FAIL stripe_off: got active=%b, required 0", active);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_skip_wrap();
    test_backpressure();
    test_drain();
    test_reset_mid();
    test_stripe();
    repeat (2) cyc();
    n_checks++;
    if (sb_q.size() != 0) $display("FAIL sb_leftover: got %0d entries, required 0", sb_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
